// File: rtl/link_demux_rx.sv
// link_demux_rx: receiving end of the two-source serial link.
// Deserialises a frame {start=0, sel, data MSB..LSB, even parity}. It checks
// parity, routes the payload to destination A or B by sel, and counts the
// accepted words for each destination.
// Ports:
//   clk_2            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   rx_line          serial input, idles high
//   dest_a / dest_b  last accepted payload for each destination
//   valid_a/valid_b  one-cycle pulse after a destination is updated
//   par_err          one-cycle pulse after a frame is rejected for bad parity
//   busy             high while a frame is in progress
//   cnt_a / cnt_b    accepted-word counters, wrap modulo 2^NBITS_CNT
module link_demux_rx #(
    parameter int NBITS_DATA = 2,
    parameter int NBITS_CNT  = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  rx_line,
    output logic [NBITS_DATA-1:0] dest_a,
    output logic [NBITS_DATA-1:0] dest_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  par_err,
    output logic                  busy,
    output logic [NBITS_CNT-1:0]  cnt_a,
    output logic [NBITS_CNT-1:0]  cnt_b
);

    // Keep the bit counter at least 1 bit wide so a 1-bit payload still works.
    localparam int CW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;

    typedef enum logic [1:0] {IDLE, SEL, DATA, PAR} state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [NBITS_DATA-1:0] payload_q, payload_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [NBITS_DATA-1:0] dest_a_q, dest_a_d, dest_b_q, dest_b_d;
    logic [NBITS_CNT-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic                  valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic                  par_err_q, par_err_d;

    // State register
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_line) state_d = SEL;
            SEL:     state_d = DATA;
            DATA:    if (bitcnt_q == '0) state_d = PAR;
            PAR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and commit logic. The pulse flops default to 0, so each pulse
    // lasts only for the cycle that follows the parity edge.
    always_comb begin
        sel_d     = sel_q;
        payload_d = payload_q;
        bitcnt_d  = bitcnt_q;
        dest_a_d  = dest_a_q;
        dest_b_d  = dest_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        par_err_d = 1'b0;
        case (state_q)
            SEL: begin
                sel_d    = rx_line;
                bitcnt_d = CW'(NBITS_DATA - 1);
            end
            DATA: begin
                // Shift in MSB first; the top bit falls off the truncation.
                payload_d = NBITS_DATA'({payload_q, rx_line});
                bitcnt_d  = bitcnt_q - CW'(1);
            end
            PAR: begin
                if (sel_q ^ (^payload_q) ^ rx_line) begin
                    par_err_d = 1'b1;
                end else if (sel_q) begin
                    dest_b_d  = payload_q;
                    cnt_b_d   = cnt_b_q + NBITS_CNT'(1);
                    valid_b_d = 1'b1;
                end else begin
                    dest_a_d  = payload_q;
                    cnt_a_d   = cnt_a_q + NBITS_CNT'(1);
                    valid_a_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= 1'b0;
            payload_q <= '0;
            bitcnt_q  <= '0;
            dest_a_q  <= '0;
            dest_b_q  <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            payload_q <= payload_d;
            bitcnt_q  <= bitcnt_d;
            dest_a_q  <= dest_a_d;
            dest_b_q  <= dest_b_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            par_err_q <= par_err_d;
        end
    end

    // Output logic
    always_comb begin
        busy    = (state_q != IDLE);
        dest_a  = dest_a_q;
        dest_b  = dest_b_q;
        cnt_a   = cnt_a_q;
        cnt_b   = cnt_b_q;
        valid_a = valid_a_q;
        valid_b = valid_b_q;
        par_err = par_err_q;
    end

endmodule

// File: tb/tb_link_demux_rx.sv
// Testbench for link_demux_rx: directed frames from the test plan followed by
// random frames. A frame-level reference model tracks the expected state.
module tb_link_demux_rx;

    localparam int NB = 2;
    localparam int NC = 4;

    logic          clk_2 = 1'b0;
    logic          reset_n = 1'b1;
    logic          rx_line = 1'b1;
    logic [NB-1:0] dest_a, dest_b;
    logic          valid_a, valid_b, par_err, busy;
    logic [NC-1:0] cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, updated once per completed frame.
    int m_dest_a, m_dest_b, m_cnt_a, m_cnt_b;
    int m_va, m_vb, m_pe;

    link_demux_rx #(.NBITS_DATA(NB), .NBITS_CNT(NC)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .rx_line (rx_line),
        .dest_a  (dest_a),
        .dest_b  (dest_b),
        .valid_a (valid_a),
        .valid_b (valid_b),
        .par_err (par_err),
        .busy    (busy),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dest_a = 0; m_dest_b = 0; m_cnt_a = 0; m_cnt_b = 0;
        m_va = 0; m_vb = 0; m_pe = 0;
    endtask

    // A frame is accepted when sel, data and parity together hold an even number of ones.
    task automatic model_frame(input int sel, input int data, input int par);
        int ones;
        ones = sel + par;
        for (int i = 0; i < NB; i++) ones += (data >> i) & 1;
        m_va = 0; m_vb = 0; m_pe = 0;
        if (ones % 2 != 0) begin
            m_pe = 1;
        end else if (sel == 1) begin
            m_dest_b = data; m_cnt_b = (m_cnt_b + 1) % (1 << NC); m_vb = 1;
        end else begin
            m_dest_a = data; m_cnt_a = (m_cnt_a + 1) % (1 << NC); m_va = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dest_a"},  int'(dest_a),  m_dest_a);
        chk({tag, ".dest_b"},  int'(dest_b),  m_dest_b);
        chk({tag, ".cnt_a"},   int'(cnt_a),   m_cnt_a);
        chk({tag, ".cnt_b"},   int'(cnt_b),   m_cnt_b);
        chk({tag, ".valid_a"}, int'(valid_a), m_va);
        chk({tag, ".valid_b"}, int'(valid_b), m_vb);
        chk({tag, ".par_err"}, int'(par_err), m_pe);
        chk({tag, ".busy"},    int'(busy),    0);
    endtask

    // Drive one complete frame, one bit per edge. Busy and the absence of
    // pulses are checked inside the frame; all outputs are checked after the
    // parity edge. rx_line is returned to idle so a caller may go straight
    // into another frame.
    task automatic send_frame(input string tag, input int sel, input int data, input int par);
        int bits[$];
        bits.push_back(0);
        bits.push_back(sel);
        for (int i = NB - 1; i >= 0; i--) bits.push_back((data >> i) & 1);
        bits.push_back(par);
        foreach (bits[k]) begin
            rx_line = bits[k][0];
            @(posedge clk_2); #1;
            if (k < bits.size() - 1) begin
                chk({tag, ".busy_in_frame"}, int'(busy), 1);
                chk({tag, ".no_pulse"}, int'(valid_a | valid_b | par_err), 0);
            end
        end
        model_frame(sel, data, par);
        check_all(tag);
        rx_line = 1'b1;
    endtask

    function automatic int even_par(input int sel, input int data);
        int ones;
        ones = sel;
        for (int i = 0; i < NB; i++) ones += (data >> i) & 1;
        return ones % 2;
    endfunction

    task automatic idle_cycles(input string tag, input int n);
        rx_line = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2); #1;
            m_va = 0; m_vb = 0; m_pe = 0;
            check_all(tag);
        end
    endtask

    initial begin
        model_reset();

        // Reset, then idle
        #1 reset_n = 1'b0;
        #1 check_all("reset_async");
        repeat (3) @(posedge clk_2);
        #1 check_all("reset_hold");
        reset_n = 1'b1;
        idle_cycles("idle_after_reset", 10);

        // Frame B
        send_frame("frame_b", 1, 2'b10, 0);
        idle_cycles("after_b", 2);

        // A then B back-to-back
        send_frame("b2b_a", 0, 2'b11, 0);
        send_frame("b2b_b", 1, 2'b01, 0);
        idle_cycles("after_b2b", 1);

        // Parity error
        send_frame("par_err", 0, 2'b01, 0);
        idle_cycles("after_par_err", 1);

        // Start from a clean state so that 16 accepted A frames wrap cnt_a to 0
        reset_n = 1'b0;
        model_reset();
        #1 check_all("reset_before_wrap");
        @(posedge clk_2); #1 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            int d;
            d = int'($urandom_range(0, (1 << NB) - 1));
            send_frame("wrap_a", 0, d, even_par(0, d));
        end
        chk("wrap_cnt_a_zero", int'(cnt_a), 0);

        // Partial frame (start, sel, first data bit) cut off by an async reset
        rx_line = 1'b0; @(posedge clk_2); #1;
        rx_line = 1'b1; @(posedge clk_2); #1;
        rx_line = 1'b1; @(posedge clk_2); #3;
        reset_n = 1'b0;
        model_reset();
        #1 check_all("midframe_reset");
        @(posedge clk_2); #1;
        rx_line = 1'b1;
        reset_n = 1'b1;
        idle_cycles("after_midframe_reset", 2);
        send_frame("post_reset_frame", 1, 2'b11, 0);

        // Random frames, with about half of them carrying a wrong parity bit
        for (int i = 0; i < 60; i++) begin
            int s, d, p;
            s = int'($urandom_range(0, 1));
            d = int'($urandom_range(0, (1 << NB) - 1));
            p = even_par(s, d) ^ int'($urandom_range(0, 1));
            send_frame("rand", s, d, p);
            if ($urandom_range(0, 2) == 0) idle_cycles("rand_idle", int'($urandom_range(1, 3)));
        end
        idle_cycles("final_idle", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
